// File: rtl/key_debounce4_if.sv
// Bundles the raw push-button pins with the debounced level and event pulses.
// key: raw active-low pins into the debouncer; key_state/key_press/key_release/key_long: its outputs.
// master = the board/pin side that drives key; slave = the debouncer.
interface key_debounce4_if;
    logic [3:0] key;
    logic [3:0] key_state;
    logic [3:0] key_press;
    logic [3:0] key_release;
    logic [3:0] key_long;

    modport master (
        output key,
        input  key_state,
        input  key_press,
        input  key_release,
        input  key_long
    );

    modport slave (
        input  key,
        output key_state,
        output key_press,
        output key_release,
        output key_long
    );
endinterface

// File: rtl/key_debounce4.sv
// Debounces four active-low push-buttons into a level plus press/release/long-press pulses.
// Latency: press/release visible T_DB+2 edges after the first edge sampling the new pin level.
// No backpressure: pulses are single-cycle and are not held for a consumer.
//
// Ports: clk, rst_n (synchronous, active-low), kb (slave modport):
//   kb.key raw pins (0 = pressed), kb.key_state debounced level (1 = pressed),
//   kb.key_press / kb.key_release / kb.key_long one-cycle event pulses per key.
module key_debounce4 #(
    parameter int T_DB   = 1_000_000,
    parameter int T_LONG = 50_000_000
) (
    input  logic           clk,
    input  logic           rst_n,
    key_debounce4_if.slave kb
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PWAIT   = 2'd1,
        PRESSED = 2'd2,
        RWAIT   = 2'd3
    } state_t;

    localparam logic [25:0] DB_LAST   = 26'(T_DB - 1);
    localparam logic [25:0] LONG_LAST = 26'(T_LONG - 1);

    // Two-flop synchronizer; key_s_q is the only view of the pins the FSMs use.
    logic [3:0]  sync1_q, sync1_d;
    logic [3:0]  key_s_q, key_s_d;

    state_t      state_q [4];
    state_t      state_d [4];
    logic [25:0] cnt_q   [4];
    logic [25:0] cnt_d   [4];
    logic [3:0]  long_done_q, long_done_d;

    logic [3:0]  key_state_q,   key_state_d;
    logic [3:0]  key_press_q,   key_press_d;
    logic [3:0]  key_release_q, key_release_d;
    logic [3:0]  key_long_q,    key_long_d;

    always_comb begin
        sync1_d       = kb.key;
        key_s_d       = sync1_q;
        long_done_d   = long_done_q;
        key_state_d   = key_state_q;
        key_press_d   = 4'b0000;
        key_release_d = 4'b0000;
        key_long_d    = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
        end

        for (int i = 0; i < 4; i++) begin
            case (state_q[i])
                IDLE: begin
                    cnt_d[i]       = '0;
                    key_state_d[i] = 1'b0;
                    if (!key_s_q[i]) begin
                        state_d[i] = PWAIT;
                    end
                end
                PWAIT: begin
                    if (key_s_q[i]) begin
                        // Bounce: drop back silently.
                        state_d[i] = IDLE;
                        cnt_d[i]   = '0;
                    end else if (cnt_q[i] == DB_LAST) begin
                        state_d[i]     = PRESSED;
                        cnt_d[i]       = '0;
                        long_done_d[i] = 1'b0;
                        key_state_d[i] = 1'b1;
                        key_press_d[i] = 1'b1;
                    end else begin
                        cnt_d[i] = 26'(cnt_q[i] + 26'd1);
                    end
                end
                PRESSED: begin
                    if (key_s_q[i]) begin
                        state_d[i] = RWAIT;
                        cnt_d[i]   = '0;
                    end else if (cnt_q[i] < LONG_LAST) begin
                        cnt_d[i] = 26'(cnt_q[i] + 26'd1);
                    end else if (!long_done_q[i]) begin
                        // Counter parks at LONG_LAST; long_done stops a repeat.
                        key_long_d[i]  = 1'b1;
                        long_done_d[i] = 1'b1;
                    end
                end
                RWAIT: begin
                    if (!key_s_q[i]) begin
                        // Release bounce: resume holding, long_done kept so no repeat event.
                        state_d[i] = PRESSED;
                        cnt_d[i]   = '0;
                    end else if (cnt_q[i] == DB_LAST) begin
                        state_d[i]       = IDLE;
                        cnt_d[i]         = '0;
                        key_state_d[i]   = 1'b0;
                        key_release_d[i] = 1'b1;
                    end else begin
                        cnt_d[i] = 26'(cnt_q[i] + 26'd1);
                    end
                end
                default: begin
                    state_d[i]     = IDLE;
                    cnt_d[i]       = '0;
                    key_state_d[i] = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q       <= 4'b1111;
            key_s_q       <= 4'b1111;
            long_done_q   <= 4'b0000;
            key_state_q   <= 4'b0000;
            key_press_q   <= 4'b0000;
            key_release_q <= 4'b0000;
            key_long_q    <= 4'b0000;
            for (int i = 0; i < 4; i++) begin
                state_q[i] <= IDLE;
                cnt_q[i]   <= '0;
            end
        end else begin
            sync1_q       <= sync1_d;
            key_s_q       <= key_s_d;
            long_done_q   <= long_done_d;
            key_state_q   <= key_state_d;
            key_press_q   <= key_press_d;
            key_release_q <= key_release_d;
            key_long_q    <= key_long_d;
            for (int i = 0; i < 4; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
        end
    end

    assign kb.key_state   = key_state_q;
    assign kb.key_press   = key_press_q;
    assign kb.key_release = key_release_q;
    assign kb.key_long    = key_long_q;

endmodule

// File: tb/tb_key_debounce4.sv
// Bench for key_debounce4: directed scenarios plus randomized per-key bouncing.
// A run-length model of the debounced behaviour is compared every cycle.
// Inputs change on the falling clock edge; outputs are sampled there too.
module tb_key_debounce4;
    localparam int T_DB   = 8;
    localparam int T_LONG = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    key_debounce4_if kif ();

    key_debounce4 #(
        .T_DB   (T_DB),
        .T_LONG (T_LONG)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .kb    (kif)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Observed pulse counts per key, accumulated between clears.
    int pc  [4];
    int prc [4];
    int plc [4];

    // Behavioural model: the synchronizer is a two-sample delay, and each
    // key's events are decided from run lengths of the delayed samples.
    logic [3:0] m_sync1 = 4'b1111;
    logic [3:0] m_sync2 = 4'b1111;
    logic [3:0] m_state = '0, m_press = '0, m_rel = '0, m_long = '0;
    int run0 [4];
    int run1 [4];
    int anchor [4];
    bit ldone [4];
    int t = 0;

    always @(posedge clk) begin
        t = t + 1;
        if (!rst_n) begin
            m_sync1 = 4'b1111;
            m_sync2 = 4'b1111;
            m_state = '0;
            m_press = '0;
            m_rel   = '0;
            m_long  = '0;
            for (int i = 0; i < 4; i++) begin
                run0[i]  = 0;
                run1[i]  = 0;
                ldone[i] = 1'b0;
            end
        end else begin
            m_press = '0;
            m_rel   = '0;
            m_long  = '0;
            for (int i = 0; i < 4; i++) begin
                if (m_sync2[i] == 1'b0) begin
                    run0[i] = run0[i] + 1;
                    run1[i] = 0;
                end else begin
                    run1[i] = run1[i] + 1;
                    run0[i] = 0;
                end
                if (!m_state[i]) begin
                    // Pressed once T_DB+1 consecutive low samples are seen.
                    if (run0[i] == T_DB + 1) begin
                        m_state[i] = 1'b1;
                        m_press[i] = 1'b1;
                        ldone[i]   = 1'b0;
                        anchor[i]  = t;
                    end
                end else begin
                    if (run1[i] == T_DB + 1) begin
                        m_state[i] = 1'b0;
                        m_rel[i]   = 1'b1;
                    end else if (m_sync2[i] == 1'b0) begin
                        // The hold timer restarts on the first low sample after a glitch.
                        if (run0[i] == 1) anchor[i] = t;
                        if (!ldone[i] && (t - anchor[i]) == T_LONG) begin
                            m_long[i] = 1'b1;
                            ldone[i]  = 1'b1;
                        end
                    end
                end
            end
            m_sync2 = m_sync1;
            m_sync1 = kif.key;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (act === exp) n_pass = n_pass + 1;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic clear_counts();
        for (int i = 0; i < 4; i++) begin
            pc[i]  = 0;
            prc[i] = 0;
            plc[i] = 0;
        end
    endtask

    // Advance n falling edges; at each one compare DUT against the model and tally pulses.
    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            check("sb_state",   kif.key_state,   m_state);
            check("sb_press",   kif.key_press,   m_press);
            check("sb_release", kif.key_release, m_rel);
            check("sb_long",    kif.key_long,    m_long);
            for (int i = 0; i < 4; i++) begin
                if (kif.key_press[i])   pc[i]  = pc[i] + 1;
                if (kif.key_release[i]) prc[i] = prc[i] + 1;
                if (kif.key_long[i])    plc[i] = plc[i] + 1;
            end
        end
    endtask

    int cd [4];
    logic [3:0] k;

    initial begin
        clear_counts();
        // Reset with all keys held down.
        rst_n   = 1'b0;
        kif.key = 4'b0000;
        tick(3);
        check("rst_state", kif.key_state, 4'b0000);
        check("rst_press", kif.key_press, 4'b0000);
        check("rst_long",  kif.key_long,  4'b0000);
        rst_n   = 1'b1;
        kif.key = 4'b1111;
        tick(100);
        check("idle_pulses", pc[0] + pc[1] + pc[2] + pc[3] + prc[0] + prc[1] + prc[2] + prc[3], 0);

        // Clean press/release on key 0, held 40 cycles.
        clear_counts();
        kif.key[0] = 1'b0;
        tick(T_DB + 2);
        check("press0_early", pc[0], 0);
        tick(1);
        check("press0_time",  kif.key_press, 4'b0001);
        check("model_press0", m_press, 4'b0001);
        tick(1);
        check("press0_single", kif.key_press, 4'b0000);
        tick(40 - (T_DB + 4));
        check("state0_held", kif.key_state, 4'b0001);
        kif.key[0] = 1'b1;
        tick(T_DB + 2);
        check("release0_early", prc[0], 0);
        tick(1);
        check("release0_time", kif.key_release, 4'b0001);
        check("state0_fall",   kif.key_state,   4'b0000);
        tick(2);
        check("no_long0", plc[0], 0);

        // Bounce rejection on key 1.
        clear_counts();
        for (int j = 0; j < 10; j++) begin
            kif.key[1] = (j % 2 == 0) ? 1'b0 : 1'b1;
            tick(3);
        end
        tick(20);
        check("bounce_press", pc[1], 0);
        check("bounce_state", kif.key_state, 4'b0000);
        kif.key[1] = 1'b0;
        tick(20);
        kif.key[1] = 1'b1;
        tick(20);
        check("press1_once",   pc[1],  1);
        check("release1_once", prc[1], 1);

        // Long press on key 2, then a release glitch.
        clear_counts();
        kif.key[2] = 1'b0;
        tick(T_DB + 3);
        check("press2_time", kif.key_press, 4'b0100);
        tick(T_LONG - 1);
        check("long2_early", plc[2], 0);
        tick(1);
        check("long2_time", kif.key_long, 4'b0100);
        check("model_long2", m_long, 4'b0100);
        tick(56);
        kif.key[2] = 1'b1;
        tick(3);
        kif.key[2] = 1'b0;
        tick(60);
        kif.key[2] = 1'b1;
        tick(20);
        check("press2_once",   pc[2],  1);
        check("long2_once",    plc[2], 1);
        check("release2_once", prc[2], 1);

        // All keys at once, then reset while held.
        clear_counts();
        kif.key = 4'b0000;
        tick(T_DB + 2);
        check("all_early", kif.key_press, 4'b0000);
        tick(1);
        check("all_press", kif.key_press, 4'b1111);
        tick(5);
        rst_n = 1'b0;
        tick(2);
        check("midrst_state", kif.key_state, 4'b0000);
        rst_n = 1'b1;
        tick(T_DB + 2);
        check("midrst_no_release", prc[0] + prc[1] + prc[2] + prc[3], 0);
        check("repress_early", kif.key_press, 4'b0000);
        tick(1);
        check("repress_all", kif.key_press, 4'b1111);
        kif.key = 4'b1111;
        tick(20);

        // Randomized per-key bouncing with occasional resets.
        for (int i = 0; i < 4; i++) cd[i] = $urandom_range(1, 40);
        for (int c = 0; c < 4000; c++) begin
            k = kif.key;
            for (int i = 0; i < 4; i++) begin
                if (cd[i] == 0) begin
                    k[i]  = ~k[i];
                    cd[i] = ($urandom_range(0, 1) == 0) ? $urandom_range(1, 6) : $urandom_range(10, 60);
                end else begin
                    cd[i] = cd[i] - 1;
                end
            end
            kif.key = k;
            rst_n   = ($urandom_range(0, 699) == 0) ? 1'b0 : 1'b1;
            tick(1);
        end
        rst_n = 1'b1;
        kif.key = 4'b1111;
        tick(20);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/key_debounce4.md
Name: key_debounce4

Overview:
- Input-side counterpart to the LED output drivers: reads the four DE2 push-buttons (KEY[3:0], active-low, mechanically bouncing).
- Produces clean, single-cycle press, release and long-press events plus debounced levels for consumers such as LED pattern and state-machine controllers.
- Four independent per-key channels share one clock.

Parameters:
- T_DB, 1_000_000, debounce stable time in clk cycles (20 ms at 50 MHz); legal range 2..2^26-1.
- T_LONG, 50_000_000, hold time in clk cycles for the long-press event (1 s at 50 MHz); must be > T_DB; max 2^26-1.

Ports:
- clk  input  1  system clock, 50 MHz.
- rst_n  input  1  reset, synchronous, active-low.
- key  input  4  raw push-button pins; 0 = pressed; asynchronous to clk.
- key_state  output  4  debounced level per key; 1 = pressed.
- key_press  output  4  one-cycle pulse per key on a debounced press.
- key_release  output  4  one-cycle pulse per key on a debounced release.
- key_long  output  4  one-cycle pulse per key when held T_LONG cycles.

Behaviour:
- Reset: rst_n sampled low at a clk edge sets:
  - key_state, key_press, key_release and key_long to 4'b0000.
  - Both synchronizer stages to 4'b1111.
  - All FSMs to IDLE, all counters to 0, all long_done flags to 0.
- Reset mid-press: no release or long event is generated; after reset the key is treated as a new event and needs T_DB stable-low cycles to re-press.
- Synchronizer: two flops per bit; key_s is the second stage. All FSM decisions use key_s only.
- Per key i, one FSM with a 26-bit counter cnt and a flag long_done:
  - IDLE: key_s=1 -> stay, cnt=0. key_s=0 -> PWAIT, cnt=0.
  - PWAIT: key_s=1 -> IDLE, cnt=0 (bounce rejected, no event). cnt==T_DB-1 -> PRESSED, cnt=0, long_done=0, key_state[i]=1, key_press[i]=1 for one cycle. Otherwise cnt+1.
  - PRESSED: key_s=1 -> RWAIT, cnt=0. Otherwise:
    - cnt<T_LONG-1: cnt+1.
    - cnt==T_LONG-1 and long_done=0: key_long[i]=1 for one cycle, long_done=1, cnt holds.
    - long_done=1: cnt holds (saturates, no wrap).
  - RWAIT: key_state[i] stays 1.
    - key_s=0 -> PRESSED, cnt=0, long_done kept. A bounce during release causes no second press or long event.
    - cnt==T_DB-1 -> IDLE, cnt=0, key_state[i]=0, key_release[i]=1 for one cycle.
    - Otherwise cnt+1.
  - Illegal state encodings -> IDLE.
- Latency, clean press (pin stable low from edge E0): key_press[i] and key_state[i] rise at edge E0+T_DB+2 (2 sync stages plus T_DB counting). Release is symmetric for key_release[i] and the fall of key_state[i].
- Long press: key_long[i] asserts T_LONG cycles after key_press[i], at most once per press.
- Pulse exclusivity:
  - key_press, key_release and key_long are never high in the same cycle for the same key.
  - Each is registered and low on the following cycle.
- Channels are fully independent. Simultaneous presses on several keys produce simultaneous pulses in the same cycle.
- All outputs are registered; there is no combinational path from key to any output.

Test Plan:
- Reset/idle (T_DB=8, T_LONG=32): hold rst_n=0 for 3 cycles with key=4'b0000 -> all outputs 0. Release reset with key=4'b1111 for 100 cycles -> no pulses.
- Clean press and release on key[0]: key[0]=0 for 40 cycles, then 1 -> key_press=4'b0001 exactly 10 edges after the fall, for one cycle. key_state[0]=1 until key_release=4'b0001 10 edges after the rise. No key_long.
- Bounce rejection: key[1] toggles every 3 cycles for 30 cycles, then stays 1 -> zero pulses, key_state stays 0. Then key[1] low for 20 cycles -> a single key_press=4'b0010.
- Long press on key[2]: held low 100 cycles -> key_press[2] once, then key_long[2] exactly 32 cycles later, once. A 3-cycle release glitch after that -> no extra key_press or key_long; final release -> one key_release[2].
- Simultaneous keys plus mid-press reset: key=4'b0000 applied at once -> key_press=4'b1111 in a single cycle. rst_n=0 while held -> all outputs clear with no key_release. After rst_n=1 with keys still low -> key_press=4'b1111 again T_DB+2 edges later.
